// File: rtl/timer_display_mux_if.sv
// timer_display_mux_if: binary time inputs and multiplexed 7-segment outputs of the display stage
interface timer_display_mux_if;
    logic [6:0] i_hours;
    logic [5:0] i_minutes;
    logic [5:0] i_seconds;
    logic [6:0] o_seg;
    logic [5:0] o_an;
    logic       o_dp;
    logic       o_bcd_valid;
    modport master (output i_hours, i_minutes, i_seconds, input o_seg, o_an, o_dp, o_bcd_valid);
    modport slave (input i_hours, i_minutes, i_seconds, output o_seg, o_an, o_dp, o_bcd_valid);
endinterface

// File: rtl/timer_display_mux.sv
// timer_display_mux: HH:MM:SS to BCD via subtract-by-10 FSM, driving a 6-digit multiplexed 7-seg display
// Optional macro LEADING_ZERO_BLANK_EN blanks the hours tens digit when it is zero.
module timer_display_mux #(
    parameter int SCAN_DIV   = 50_000,
    parameter int CONV_STEPS = 10
) (
    input logic            i_clk,
    input logic            i_rst,
    timer_display_mux_if.slave bus
);
    localparam int NSTEP = 3 * CONV_STEPS;
    localparam int SW = $clog2(NSTEP);
    localparam int DW = $clog2(SCAN_DIV);
    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
    state_t        state_q;
    logic [SW-1:0] step_q;
    logic [6:0]    snap_h_q, work_h_q;
    logic [5:0]    snap_m_q, snap_s_q, work_m_q, work_s_q;
    logic [3:0]    ten_h_q, ten_m_q, ten_s_q;
    logic [3:0]    dig_q [6];
    logic          dash_h_q, dash_m_q, dash_s_q, valid_q;
    logic [DW-1:0] div_q;
    logic [2:0]    idx_q, idx_d;
    logic          on_q, on_d, wrap, dash_cur, blank;
    logic [3:0]    cur;
    logic [6:0]    seg_d, seg_q;
    logic [5:0]    an_q;
    logic          dp_q;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Converter FSM: snapshot on change, 30 subtract steps, then commit all six digits at once
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            step_q   <= '0;
            snap_h_q <= '0;
            snap_m_q <= '0;
            snap_s_q <= '0;
            work_h_q <= '0;
            work_m_q <= '0;
            work_s_q <= '0;
            ten_h_q  <= '0;
            ten_m_q  <= '0;
            ten_s_q  <= '0;
            dig_q    <= '{default: '0};
            dash_h_q <= 1'b0;
            dash_m_q <= 1'b0;
            dash_s_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if ({bus.i_hours, bus.i_minutes, bus.i_seconds} != {snap_h_q, snap_m_q, snap_s_q}) begin
                    snap_h_q <= bus.i_hours;
                    snap_m_q <= bus.i_minutes;
                    snap_s_q <= bus.i_seconds;
                    work_h_q <= bus.i_hours;
                    work_m_q <= bus.i_minutes;
                    work_s_q <= bus.i_seconds;
                    ten_h_q  <= '0;
                    ten_m_q  <= '0;
                    ten_s_q  <= '0;
                    step_q   <= '0;
                    state_q  <= CONV;
                end
                CONV: begin
                    if (step_q < SW'(CONV_STEPS)) begin
                        if (work_h_q >= 7'd10) begin
                            work_h_q <= work_h_q - 7'd10;
                            ten_h_q  <= ten_h_q + 4'd1;
                        end
                    end else if (step_q < SW'(2 * CONV_STEPS)) begin
                        if (work_m_q >= 6'd10) begin
                            work_m_q <= work_m_q - 6'd10;
                            ten_m_q  <= ten_m_q + 4'd1;
                        end
                    end else if (work_s_q >= 6'd10) begin
                        work_s_q <= work_s_q - 6'd10;
                        ten_s_q  <= ten_s_q + 4'd1;
                    end
                    step_q <= step_q + 1'b1;
                    if (step_q == SW'(NSTEP - 1)) state_q <= COMMIT;
                end
                default: begin
                    dig_q    <= '{ten_h_q, work_h_q[3:0], ten_m_q, work_m_q[3:0], ten_s_q, work_s_q[3:0]};
                    dash_h_q <= snap_h_q > 7'd99;
                    dash_m_q <= snap_m_q > 6'd59;
                    dash_s_q <= snap_s_q > 6'd59;
                    valid_q  <= 1'b1;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Scan slot selection and segment pattern for the slot about to be shown
    always_comb begin
        wrap     = div_q == DW'(SCAN_DIV - 1);
        on_d     = on_q | wrap;
        idx_d    = (wrap && on_q) ? (idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1) : idx_q;
        cur      = dig_q[idx_d];
        dash_cur = idx_d < 3'd2 ? dash_h_q : idx_d < 3'd4 ? dash_m_q : dash_s_q;
`ifdef LEADING_ZERO_BLANK_EN
        blank    = idx_d == 3'd0 && cur == 4'd0;
`else
        blank    = 1'b0;
`endif
        seg_d    = dash_cur ? 7'b0111111 : blank ? 7'h7F : seg7(cur);
    end

    // Divider, scan index and registered display drive; all-dark until the first divider wrap
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_q <= '0;
            idx_q <= '0;
            on_q  <= 1'b0;
            seg_q <= 7'h7F;
            an_q  <= 6'h3F;
            dp_q  <= 1'b1;
        end else begin
            div_q <= wrap ? '0 : div_q + 1'b1;
            idx_q <= idx_d;
            on_q  <= on_d;
            seg_q <= on_d ? seg_d : 7'h7F;
            an_q  <= on_d ? ~(6'b100000 >> idx_d) : 6'h3F;
            dp_q  <= ~(on_d && (idx_d == 3'd1 || idx_d == 3'd3));
        end
    end

    assign bus.o_seg       = seg_q;
    assign bus.o_an        = an_q;
    assign bus.o_dp        = dp_q;
    assign bus.o_bcd_valid = valid_q;
endmodule

// File: tb/tb_timer_display_mux.sv
// tb_timer_display_mux: scoreboard bench; stimulus queues expected digit sets, monitor checks each commit
module tb_timer_display_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   busy = 1'b0;
    typedef struct {
        logic [41:0] seg;
        int          lo;
        int          hi;
    } exp_t;
    exp_t sb [$];
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] HZ = 7'h7F;
`else
    localparam logic [6:0] HZ = 7'h40;
`endif

    timer_display_mux_if bus ();
    timer_display_mux #(.SCAN_DIV(4), .CONV_STEPS(10)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic scan_check(input logic [41:0] es);
        logic [6:0] got [6];
        logic       gdp [6];
        logic [5:0] seen;
        int         n;
        seen = '0;
        n = 0;
        while (seen != 6'h3F && n < 60) begin
            @(posedge clk); #1;
            n++;
            for (int k = 0; k < 6; k++)
                if (bus.o_an == ~(6'b100000 >> k)) begin
                    got[k]  = bus.o_seg;
                    gdp[k]  = bus.o_dp;
                    seen[k] = 1'b1;
                end
        end
        chk("scan_complete", int'(seen), 'h3F);
        if (seen == 6'h3F)
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("seg_slot%0d", k), int'(got[k]), int'(es[41-7*k -: 7]));
                chk($sformatf("dp_slot%0d", k), int'(gdp[k]), (k == 1 || k == 3) ? 0 : 1);
            end
    endtask

    // Monitor: every o_bcd_valid pops one expectation, checks its cycle window and the next full scan
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (bus.o_bcd_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid got pulse want none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (cyc < e.lo || cyc > e.hi) begin
                        errors++;
                        $display("FAIL valid_cycle got %0d want %0d..%0d", cyc, e.lo, e.hi);
                    end
                    busy = 1'b1;
                    scan_check(e.seg);
                    busy = 1'b0;
                end
            end
        end
    end

    task automatic drive(input int h, input int m, input int s);
        @(negedge clk);
        bus.i_hours   = 7'(h);
        bus.i_minutes = 6'(m);
        bus.i_seconds = 6'(s);
    endtask

    task automatic push(input logic [41:0] seg, input int lo, input int hi);
        exp_t e;
        e.seg = seg;
        e.lo  = lo;
        e.hi  = hi;
        sb.push_back(e);
    endtask

    task automatic apply(input int h, input int m, input int s, input logic [41:0] seg);
        drive(h, m, s);
        push(seg, cyc + 32, cyc + 32);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int t0, n, vcnt, achg;
        logic [5:0] prev;
        bus.i_hours   = '0;
        bus.i_minutes = '0;
        bus.i_seconds = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", bus.o_seg, 'h7F);
        chk("rst_an", bus.o_an, 'h3F);
        chk("rst_dp", bus.o_dp, 1);
        chk("rst_valid", bus.o_bcd_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        // Basic conversion and latency
        apply(12, 34, 56, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        wait_idle();
        // Reset mid-conversion aborts; the still-different input is re-converted after release
        drive(23, 45, 7);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_seg", bus.o_seg, 'h7F);
        chk("midrst_an", bus.o_an, 'h3F);
        chk("midrst_dp", bus.o_dp, 1);
        chk("midrst_valid", bus.o_bcd_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
        push({7'h24, 7'h30, 7'h19, 7'h12, 7'h40, 7'h78}, t0 + 32, t0 + 32);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.o_an == 6'h3F && n < 20);
        chk("first_strobe_cycles", n, 4);
        wait_idle();
        // Boundaries
        apply(99, 59, 59, {7'h10, 7'h10, 7'h12, 7'h10, 7'h12, 7'h10});
        wait_idle();
        apply(0, 0, 0, {HZ, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
        wait_idle();
        // Change during conversion: first value committed, then the final one, nothing else
        apply(0, 0, 1, {HZ, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79});
        t0 = cyc;
        repeat (10) @(negedge clk);
        bus.i_seconds = 6'd2;
        push({HZ, 7'h40, 7'h40, 7'h40, 7'h40, 7'h24}, t0 + 64, t0 + 66);
        wait_idle();
        // Out-of-range hours and minutes show dashes
        apply(100, 60, 7, {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h78});
        wait_idle();
        // Steady input: no commits, scan keeps running
        vcnt = 0;
        achg = 0;
        @(posedge clk); #1;
        prev = bus.o_an;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (bus.o_bcd_valid) vcnt++;
            if (bus.o_an != prev) achg++;
            prev = bus.o_an;
        end
        chk("steady_valids", vcnt, 0);
        chk("steady_an_changes", achg, 250);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
